ppm16_rx_ctrl: RTL
==================

Name: ppm16_rx_ctrl

Overview:
- Receive sequencer for the PPM-16 demodulator.
- Arms the demodulator (reset, one-cycle rx_start) and programs its correlation threshold.
- Waits for packet detection, retrying with a relaxed threshold on timeout.
- Assembles demodulated 4-bit symbols into bytes on a valid/ready stream toward the host/FIFO, and reports done/error status.

Parameters:
- THR_W, 5, width of correlation threshold (peak of 16 chips).
- LEN_W, 8, width of expected payload length in bytes.
- TO_W, 16, width of timeout counters.
- SEARCH_TIMEOUT, 50000, cycles in SEARCH before a retry.
- GAP_TIMEOUT, 1024, max cycles between dout_valid pulses in RECEIVE.
- MAX_RETRIES, 3, retries after the first search attempt.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- arm  in  1  start a receive attempt; sampled in IDLE/DONE/ERROR.
- abort  in  1  cancel any operation.
- rx_len  in  LEN_W  expected payload bytes; latched on accepted arm.
- thr_init  in  THR_W  initial correlation threshold; latched on accepted arm.
- demod_resetn  out  1  active-low reset to demodulator.
- demod_rx_start  out  1  one-cycle start pulse to demodulator.
- demod_corr_threshold  out  THR_W  threshold to demodulator.
- demod_packet_detected  in  1  demodulator detection flag (level).
- demod_dout_valid  in  1  demodulator symbol strobe.
- demod_dout  in  4  demodulated symbol.
- byte_data  out  8  assembled byte.
- byte_valid  out  1  byte available.
- byte_ready  in  1  consumer accepts byte.
- busy  out  1  high in START/SEARCH/RETRY/RECEIVE.
- done  out  1  packet completed; sticky.
- error  out  1  failure; sticky.
- err_code  out  2  00 none, 01 search exhausted, 10 gap timeout, 11 overflow.
- retries_used  out  2  retries consumed in the current/last attempt.

Behaviour:
- All outputs are registered.
- Reset values:
  - Outputs: demod_resetn=0, demod_rx_start=0, demod_corr_threshold=0, byte_data=0, byte_valid=0, busy=0, done=0, error=0, err_code=00, retries_used=0.
  - Internal: state=IDLE, all counters 0.
- States: IDLE, START, SEARCH, RETRY, RECEIVE, DONE, ERROR.
- IDLE/DONE/ERROR:
  - demod_resetn=0.
  - arm accepted only if byte_valid=0. On acceptance: latch rx_len and thr_init, clear done/error/err_code/retries_used, go to START.
- START (exactly 1 cycle):
  - demod_resetn=1, demod_rx_start=1, threshold driven.
  - Next state SEARCH; timeout counter cleared.
- SEARCH:
  - A rising edge of demod_packet_detected (previous value registered, cleared in START) goes to RECEIVE, with nibble phase=high and byte count=0.
  - If rx_len=0, detection goes directly to DONE.
  - Timeout counter reaching SEARCH_TIMEOUT-1 with no edge that cycle:
    - retries_used<MAX_RETRIES → RETRY.
    - Otherwise → ERROR, err_code=01.
  - A detection edge and timeout in the same cycle resolve as detection.
  - demod_dout_valid is ignored in SEARCH.
- RETRY (1 cycle):
  - demod_resetn=0, retries_used+1.
  - Threshold decrements by 1, saturating at 1.
  - Next state START.
- RECEIVE:
  - Each demod_dout_valid alternates nibble phase. First nibble is the high nibble (MSB first); the second completes byte {hi,lo}.
  - On completion: byte_data/byte_valid update the next cycle; byte count+1.
  - The byte count reaching rx_len goes to DONE on the same edge that raises byte_valid.
  - The gap counter clears on each dout_valid. Reaching GAP_TIMEOUT-1 → ERROR, err_code=10. A pending half byte is discarded.
- Output handshake:
  - Single register.
  - byte_valid clears on valid&&ready unless a new byte loads the same cycle; then it stays high with the new data.
  - A byte completing while byte_valid=1 and byte_ready=0 → ERROR, err_code=11. The held byte is kept and still drains.
- DONE/ERROR: the done/error bit is high; the demodulator is held in reset.
- abort: any state → IDLE next cycle.
  - Drops byte_valid.
  - Clears done/error.
  - demod_resetn=0.
  - abort has priority over every other event, including arm.
- reset mid-operation: identical to the reset values above; no byte is emitted.

Test Plan:
1. Nominal receive:
   - Stimulus: arm, rx_len=2, thr_init=12; detect after 100 cycles; nibbles A,5,3,C.
   - Response: one-cycle demod_rx_start one cycle after arm; bytes 0xA5 then 0x3C, each one cycle after the low nibble; done=1, err_code=00, retries_used=0.
2. Retry path:
   - Stimulus: no detection for 2 full SEARCH_TIMEOUT windows, then detection.
   - Response: threshold 12→11→10; demod_resetn low one cycle per retry; retries_used=2; packet completes.
3. Search exhausted:
   - Stimulus: no detection ever.
   - Response: after 4 windows, error=1, err_code=01, retries_used=3; threshold ends at 9.
   - Also: thr_init=1 stays saturated at 1.
4. Backpressure:
   - Stimulus: byte_ready=0 across two completed bytes.
   - Response: err_code=11; first byte stays valid; holding ready=1 drains it.
   - Also: back-to-back completion with ready=1 produces no error.
5. Gap timeout:
   - Stimulus: one nibble then silence for GAP_TIMEOUT cycles.
   - Response: err_code=10, no byte_valid.
6. Abort and reset:
   - Stimulus: abort mid-RECEIVE.
   - Response: IDLE next cycle, byte_valid=0, busy=0, demod_resetn=0.
   - Also: arm+abort in the same cycle → stays IDLE; reset in SEARCH gives all reset values.

Source files
------------

// File: rtl/ppm16_rx_ctrl.sv
`timescale 1ns/1ps
// ppm16_rx_ctrl -- receive sequencer for the PPM-16 demodulator.
//
// Arms the demodulator (release from reset plus a one-cycle start pulse),
// programs its correlation threshold and waits for packet detection. A search
// that times out is retried with the threshold relaxed by one. Once a packet is
// detected, 4-bit symbols are paired MSB-nibble-first into bytes and offered on
// a single-register valid/ready stream. Completion and failures are reported
// through sticky done/error flags and an error code.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   arm, abort                  start a receive attempt / cancel anything
//   rx_len, thr_init            payload length and initial threshold (latched on arm)
//   demod_resetn                active-low demodulator reset
//   demod_rx_start              one-cycle demodulator start pulse
//   demod_corr_threshold        correlation threshold to the demodulator
//   demod_packet_detected       detection level from the demodulator
//   demod_dout_valid/demod_dout symbol strobe and 4-bit symbol
//   byte_data/byte_valid/byte_ready  assembled byte stream
//   busy, done, error, err_code, retries_used  status
module ppm16_rx_ctrl #(
  parameter int THR_W          = 5,
  parameter int LEN_W          = 8,
  parameter int TO_W           = 16,
  parameter int SEARCH_TIMEOUT = 50000,
  parameter int GAP_TIMEOUT    = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             abort,
  input  logic [LEN_W-1:0] rx_len,
  input  logic [THR_W-1:0] thr_init,
  output logic             demod_resetn,
  output logic             demod_rx_start,
  output logic [THR_W-1:0] demod_corr_threshold,
  input  logic             demod_packet_detected,
  input  logic             demod_dout_valid,
  input  logic [3:0]       demod_dout,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [1:0]       retries_used
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_SEARCH  = 3'd2;
  localparam logic [2:0] S_RETRY   = 3'd3;
  localparam logic [2:0] S_RECEIVE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  localparam logic [TO_W-1:0]  SEARCH_LAST = TO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  GAP_LAST    = TO_W'(GAP_TIMEOUT - 1);
  localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRIES);
  localparam logic [THR_W-1:0] THR_ONE     = THR_W'(1);

  localparam logic [1:0] E_SEARCH  = 2'b01;
  localparam logic [1:0] E_GAP     = 2'b10;
  localparam logic [1:0] E_OVERRUN = 2'b11;

  // state and datapath registers
  logic [2:0]       r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_byte_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [TO_W-1:0]  r_gap_cnt;
  logic             r_pd_prev;
  logic             r_phase;     // 0: expecting high nibble, 1: expecting low nibble
  logic [3:0]       r_hi;

  // output registers
  logic             r_demod_resetn;
  logic             r_rx_start;
  logic [THR_W-1:0] r_thr;
  logic [7:0]       r_byte_data;
  logic             r_byte_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [1:0]       r_err_code;
  logic [1:0]       r_retries;

  // next-state decode
  logic [2:0]       w_next;
  logic             w_arm_ok;
  logic             w_load;
  logic             w_err_set;
  logic [1:0]       w_err_val;
  logic             w_det_edge;
  logic             w_len_hit;

  assign w_det_edge = demod_packet_detected & ~r_pd_prev;
  assign w_len_hit  = (r_byte_cnt + LEN_W'(1)) == r_len;

  always_comb begin
    w_next    = r_state;
    w_arm_ok  = 1'b0;
    w_load    = 1'b0;
    w_err_set = 1'b0;
    w_err_val = '0;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          // a byte still waiting for the consumer blocks a new attempt
          if (arm && !r_byte_valid) begin
            w_arm_ok = 1'b1;
            w_next   = S_START;
          end
        end
        S_START: w_next = S_SEARCH;
        S_SEARCH: begin
          // detection wins over a timeout landing on the same cycle
          if (w_det_edge) begin
            w_next = (r_len == '0) ? S_DONE : S_RECEIVE;
          end else if (r_to_cnt == SEARCH_LAST) begin
            if (r_retries < RETRY_LIMIT) begin
              w_next = S_RETRY;
            end else begin
              w_next    = S_ERROR;
              w_err_set = 1'b1;
              w_err_val = E_SEARCH;
            end
          end
        end
        S_RETRY: w_next = S_START;
        S_RECEIVE: begin
          if (demod_dout_valid) begin
            if (r_phase) begin
              if (r_byte_valid && !byte_ready) begin
                // held byte is kept; the new one is dropped
                w_next    = S_ERROR;
                w_err_set = 1'b1;
                w_err_val = E_OVERRUN;
              end else begin
                w_load = 1'b1;
                if (w_len_hit) begin
                  w_next = S_DONE;
                end
              end
            end
          end else if (r_gap_cnt == GAP_LAST) begin
            w_next    = S_ERROR;
            w_err_set = 1'b1;
            w_err_val = E_GAP;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_len          <= '0;
      r_byte_cnt     <= '0;
      r_to_cnt       <= '0;
      r_gap_cnt      <= '0;
      r_pd_prev      <= 1'b0;
      r_phase        <= 1'b0;
      r_hi           <= '0;
      r_demod_resetn <= 1'b0;
      r_rx_start     <= 1'b0;
      r_thr          <= '0;
      r_byte_data    <= '0;
      r_byte_valid   <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_err_code     <= '0;
      r_retries      <= '0;
    end else begin
      r_state <= w_next;

      // control outputs are decoded from the next state so they line up
      // with the state register rather than lagging it by a cycle
      r_demod_resetn <= (w_next == S_START) || (w_next == S_SEARCH) ||
                        (w_next == S_RECEIVE);
      r_rx_start     <= (w_next == S_START);
      r_busy         <= (w_next == S_START) || (w_next == S_SEARCH) ||
                        (w_next == S_RETRY) || (w_next == S_RECEIVE);

      r_pd_prev <= (r_state == S_START) ? 1'b0 : demod_packet_detected;

      if (r_state == S_START) begin
        r_to_cnt <= '0;
      end else if (r_state == S_SEARCH) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      if (r_state == S_SEARCH && w_next == S_RECEIVE) begin
        r_gap_cnt  <= '0;
        r_phase    <= 1'b0;
        r_byte_cnt <= '0;
      end else if (r_state == S_RECEIVE) begin
        if (demod_dout_valid) begin
          r_gap_cnt <= '0;
          r_phase   <= ~r_phase;
          if (!r_phase) begin
            r_hi <= demod_dout;
          end else begin
            r_byte_cnt <= r_byte_cnt + LEN_W'(1);
          end
        end else begin
          r_gap_cnt <= r_gap_cnt + TO_W'(1);
        end
      end

      if (w_arm_ok) begin
        r_len      <= rx_len;
        r_thr      <= thr_init;
        r_done     <= 1'b0;
        r_error    <= 1'b0;
        r_err_code <= '0;
        r_retries  <= '0;
      end

      if (r_state == S_SEARCH && w_next == S_RETRY) begin
        r_retries <= r_retries + 2'd1;
        r_thr     <= (r_thr > THR_ONE) ? r_thr - THR_ONE : THR_ONE;
      end

      if (w_next == S_DONE) begin
        r_done <= 1'b1;
      end
      if (w_next == S_ERROR) begin
        r_error <= 1'b1;
      end
      if (w_err_set) begin
        r_err_code <= w_err_val;
      end

      if (abort) begin
        r_done       <= 1'b0;
        r_error      <= 1'b0;
        r_err_code   <= '0;
        r_byte_valid <= 1'b0;
      end else if (w_load) begin
        r_byte_data  <= {r_hi, demod_dout};
        r_byte_valid <= 1'b1;
      end else if (r_byte_valid && byte_ready) begin
        r_byte_valid <= 1'b0;
      end
    end
  end

  assign demod_resetn         = r_demod_resetn;
  assign demod_rx_start       = r_rx_start;
  assign demod_corr_threshold = r_thr;
  assign byte_data            = r_byte_data;
  assign byte_valid           = r_byte_valid;
  assign busy                 = r_busy;
  assign done                 = r_done;
  assign error                = r_error;
  assign err_code             = r_err_code;
  assign retries_used         = r_retries;

endmodule
